// File: rtl/tlb_lup_arbiter_pkg.sv
// Shared widths, the lookup request record and a saturating increment for the TLB lookup arbiter.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package tlb_lup_arbiter_pkg;

  localparam int VADDR_BITS    = 48;
  localparam int PID_BITS      = 6;
  localparam int TLB_DATA_BITS = 32;
  localparam int N_TLB_REQ_MAX = 8;
  localparam int CNT_BITS      = 32;

  typedef struct packed {
    logic [VADDR_BITS-1:0] addr;
    logic [PID_BITS-1:0]   pid;
    logic                  wr;
  } tlb_lup_req_t;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (v == {CNT_BITS{1'b1}}) ? v : v + CNT_BITS'(1);
  endfunction

endpackage

// File: rtl/tlb_lup_arbiter_if.sv
// Requester-side bundle (per-requester lookup request and response) plus the TLB lookup port.
// Latency: none, wiring only.
// Backpressure: request uses valid/ready per requester; response uses valid/ready per requester.
interface tlb_lup_if
  import tlb_lup_arbiter_pkg::*;
#(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]                    s_req_valid;
  logic [N_REQ-1:0]                    s_req_ready;
  logic [N_REQ-1:0][VADDR_BITS-1:0]    s_req_addr;
  logic [N_REQ-1:0][PID_BITS-1:0]      s_req_pid;
  logic [N_REQ-1:0]                    s_req_wr;
  logic [N_REQ-1:0]                    m_rsp_valid;
  logic [N_REQ-1:0]                    m_rsp_ready;
  logic [N_REQ-1:0]                    m_rsp_hit;
  logic [N_REQ-1:0][TLB_DATA_BITS-1:0] m_rsp_data;

  modport master (
    output s_req_valid, s_req_addr, s_req_pid, s_req_wr, m_rsp_ready,
    input  s_req_ready, m_rsp_valid, m_rsp_hit, m_rsp_data
  );

  modport slave (
    input  s_req_valid, s_req_addr, s_req_pid, s_req_wr, m_rsp_ready,
    output s_req_ready, m_rsp_valid, m_rsp_hit, m_rsp_data
  );
endinterface

// Lookup port of tlb_controller: one-cycle valid strobe out, registered hit/data back one cycle later.
interface tlbIntf
  import tlb_lup_arbiter_pkg::*;
;
  logic                     valid;
  logic [VADDR_BITS-1:0]    addr;
  logic [PID_BITS-1:0]      pid;
  logic                     wr;
  logic                     hit;
  logic [TLB_DATA_BITS-1:0] data;

  modport m (output valid, addr, pid, wr, input hit, data);
  modport s (input valid, addr, pid, wr, output hit, data);
endinterface

// File: rtl/tlb_lup_arbiter_rr.sv
// N-way round-robin arbiter: the search starts one past the last winner, one-hot grant and index out.
// Latency: grant is combinational from eligible in the same cycle; the pointer moves at the clock edge.
// Backpressure: none of its own; only requesters with their eligible bit set can win.
module rr_arbiter_n #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  eligible,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] cand;

  // Walk the ring once starting after the pointer; the first eligible index wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = ptr_q;
    for (int k = 0; k < N; k++) begin
      cand = (cand == IW'(N - 1)) ? '0 : cand + IW'(1);
      if (!grant_vld && eligible[cand]) begin
        grant_vld   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  // Remember the last winner; reset value makes requester 0 first in line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= IW'(N - 1);
    end else if (grant_vld) begin
      ptr_q <= grant_idx;
    end
  end

endmodule

// File: rtl/tlb_lup_arbiter.sv
// Shares one tlb_controller lookup port among N_REQ requesters, round-robin, one lookup per cycle.
// Latency: request handshake to response valid is exactly 3 cycles (issue, BRAM read, capture).
// Backpressure: one lookup outstanding per requester; a held response blocks only its own requester.
module tlb_lup_arbiter
  import tlb_lup_arbiter_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int PG_BITS   = 12,
  parameter int TLB_ORDER = 10
) (
  input  logic                aclk,
  input  logic                areset,
  tlb_lup_if.slave            lup,
  tlbIntf.m                   TLB,
  input  logic                pause,
  input  logic                stats_clr,
  output logic [CNT_BITS-1:0] lup_hit_cnt,
  output logic [CNT_BITS-1:0] lup_miss_cnt
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > N_TLB_REQ_MAX) begin : g_chk_nreq
    $error("tlb_lup_arbiter: N_REQ must be within 2..N_TLB_REQ_MAX");
  end
  if (PG_BITS + TLB_ORDER > VADDR_BITS) begin : g_chk_index
    $error("tlb_lup_arbiter: TLB index field lies outside the virtual address");
  end

  logic [N_REQ-1:0]    busy_q;
  logic [N_REQ-1:0]    eligible;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    rsp_hs;
  logic [IW-1:0]       grant_idx;
  logic                grant_vld;
  tlb_lup_req_t        gnt_req;
  tlb_lup_req_t        iss_q;
  logic                iss_vld_q;
  logic [IW-1:0]       iss_id_q;
  logic                lk_vld_q;
  logic [IW-1:0]       lk_id_q;
  logic [CNT_BITS-1:0] hit_cnt_q, miss_cnt_q;
  logic [CNT_BITS-1:0] hit_cnt_nxt, miss_cnt_nxt;

  assign rsp_hs   = lup.m_rsp_valid & lup.m_rsp_ready;
  // Reset is folded in so no grant can appear while the block is held in reset.
  assign eligible = lup.s_req_valid & ~busy_q & {N_REQ{~pause & ~areset}};

  rr_arbiter_n #(.N(N_REQ), .IW(IW)) u_rr (
    .clk       (aclk),
    .rst       (areset),
    .eligible  (eligible),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign lup.s_req_ready = grant;
  assign gnt_req = '{addr: lup.s_req_addr[grant_idx],
                     pid:  lup.s_req_pid[grant_idx],
                     wr:   lup.s_req_wr[grant_idx]};

  // Issue stage: one-cycle TLB strobe with the granted request and its requester ID.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      iss_vld_q <= 1'b0;
      iss_q     <= '0;
      iss_id_q  <= '0;
    end else begin
      iss_vld_q <= grant_vld;
      if (grant_vld) begin
        iss_q    <= gnt_req;
        iss_id_q <= grant_idx;
      end
    end
  end

  assign TLB.valid = iss_vld_q;
  assign TLB.addr  = iss_q.addr;
  assign TLB.pid   = iss_q.pid;
  assign TLB.wr    = iss_q.wr;

  // Lookup stage: the ID rides alongside the BRAM read so the result can be routed home.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      lk_vld_q <= 1'b0;
      lk_id_q  <= '0;
    end else begin
      lk_vld_q <= iss_vld_q;
      lk_id_q  <= iss_id_q;
    end
  end

  // Response registers: capture on lookup return (data zeroed on a miss), drop valid when taken.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      lup.m_rsp_valid <= '0;
      lup.m_rsp_hit   <= '0;
      lup.m_rsp_data  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (lk_vld_q && lk_id_q == IW'(i)) begin
          lup.m_rsp_valid[i] <= 1'b1;
          lup.m_rsp_hit[i]   <= TLB.hit;
          lup.m_rsp_data[i]  <= TLB.hit ? TLB.data : '0;
        end else if (rsp_hs[i]) begin
          lup.m_rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Busy covers grant through response handshake, so a requester cannot be re-granted in the handshake cycle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      busy_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i]) begin
          busy_q[i] <= 1'b1;
        end else if (rsp_hs[i]) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  // Next counter values: clear beats a same-cycle increment.
  always_comb begin
    hit_cnt_nxt  = hit_cnt_q;
    miss_cnt_nxt = miss_cnt_q;
    if (stats_clr) begin
      hit_cnt_nxt  = '0;
      miss_cnt_nxt = '0;
    end else if (lk_vld_q) begin
      if (TLB.hit) begin
        hit_cnt_nxt = sat_inc(hit_cnt_q);
      end else begin
        miss_cnt_nxt = sat_inc(miss_cnt_q);
      end
    end
  end

  // Counters reload their next value every cycle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_nxt;
      miss_cnt_q <= miss_cnt_nxt;
    end
  end

  assign lup_hit_cnt  = hit_cnt_q;
  assign lup_miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_tlb_lup_arbiter.sv
// Directed bench for tlb_lup_arbiter with a small TLB model answering one cycle after the strobe.
// Latency: checks the 3-cycle request-to-response path and the one-cycle TLB strobe.
// Backpressure: exercises held responses, pause and mid-flight reset.
module tb_tlb_lup_arbiter;

  logic        aclk;
  logic        areset;
  logic        pause;
  logic        stats_clr;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [47:0] A_HIT0 = 48'h0000_1234_5000;  // pid 3 -> CAFE_0001
  localparam logic [47:0] A_HIT1 = 48'h0000_0000_A000;  // pid 1 -> BEEF_0002
  localparam logic [47:0] A_MISS = 48'h0000_0BAD_0000;  // unmapped

  tlb_lup_if #(.N_REQ(3)) lup ();
  tlbIntf                 tlb ();

  tlb_lup_arbiter #(.N_REQ(3), .PG_BITS(12), .TLB_ORDER(10)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .lup          (lup),
    .TLB          (tlb),
    .pause        (pause),
    .stats_clr    (stats_clr),
    .lup_hit_cnt  (hit_cnt),
    .lup_miss_cnt (miss_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // TLB model: two mapped pages; a miss returns non-zero junk that the DUT must zero.
  function automatic logic [32:0] tlb_model(input logic [47:0] a, input logic [5:0] p);
    if (a[47:12] == 36'h0_0001_2345 && p == 6'd3) return {1'b1, 32'hCAFE_0001};
    if (a[47:12] == 36'h0_0000_000A && p == 6'd1) return {1'b1, 32'hBEEF_0002};
    return {1'b0, 32'h5A5A_5A5A};
  endfunction

  // Registered TLB read, one cycle after the strobe.
  always @(posedge aclk) begin
    {tlb.hit, tlb.data} <= tlb_model(tlb.addr, tlb.pid);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge aclk);
  endtask

  task automatic set_req(input int i, input logic [47:0] a, input logic [5:0] p, input logic w);
    lup.s_req_valid[i] = 1'b1;
    lup.s_req_addr[i]  = a;
    lup.s_req_pid[i]   = p;
    lup.s_req_wr[i]    = w;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    cyc();
    cyc();
    areset = 1'b0;
  endtask

  // Single lookup from an otherwise idle requester; returns at T+4 with the response taken.
  task automatic one_lookup(input int i, input logic [47:0] a, input logic [5:0] p);
    cyc();
    lup.s_req_valid = '0;
    set_req(i, a, p, 1'b0);
    cyc();
    lup.s_req_valid = '0;
    cyc();
    cyc();
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [2:0] fair_rdy [0:9];
  logic [2:0] fair_rsp [0:9];
  int gcnt0, gcnt1, gcnt2, n_v2, any_rdy, tlbv, seen0, leak;

  initial begin
    fair_rdy = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b001, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000};
    fair_rsp = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b000, 3'b001, 3'b010, 3'b100};

    areset = 1'b1;
    pause = 1'b0;
    stats_clr = 1'b0;
    lup.s_req_valid = '0;
    lup.s_req_addr = '0;
    lup.s_req_pid = '0;
    lup.s_req_wr = '0;
    lup.m_rsp_ready = '1;

    // Reset state, with requests pending to show no grant leaks through reset.
    cyc();
    cyc();
    lup.s_req_valid = 3'b111;
    #1;
    check("rst_ready", lup.s_req_ready, 3'b000);
    check("rst_rsp_valid", lup.m_rsp_valid, 3'b000);
    check("rst_tlb_valid", tlb.valid, 1'b0);
    check("rst_tlb_addr", tlb.addr, 48'h0);
    check("rst_hit_cnt", hit_cnt, 32'h0);
    check("rst_miss_cnt", miss_cnt, 32'h0);
    lup.s_req_valid = '0;
    cyc();
    areset = 1'b0;

    // Single hit from requester 0.
    cyc();
    set_req(0, A_HIT0, 6'd3, 1'b0);
    #1;
    check("hit_grant", lup.s_req_ready, 3'b001);
    cyc();
    lup.s_req_valid = '0;
    #1;
    check("hit_tlb_valid", tlb.valid, 1'b1);
    check("hit_tlb_addr", tlb.addr, A_HIT0);
    check("hit_tlb_pid", tlb.pid, 6'd3);
    cyc();
    #1;
    check("hit_tlb_pulse", tlb.valid, 1'b0);
    check("hit_rsp_early", lup.m_rsp_valid, 3'b000);
    cyc();
    #1;
    check("hit_rsp_valid", lup.m_rsp_valid, 3'b001);
    check("hit_rsp_hit", lup.m_rsp_hit[0], 1'b1);
    check("hit_rsp_data", lup.m_rsp_data[0], 32'hCAFE_0001);
    check("hit_cnt", hit_cnt, 32'd1);
    cyc();
    #1;
    check("hit_rsp_taken", lup.m_rsp_valid, 3'b000);

    // Miss from requester 1: data forced to zero despite junk from the TLB.
    set_req(1, A_MISS, 6'd1, 1'b1);
    #1;
    check("miss_grant", lup.s_req_ready, 3'b010);
    cyc();
    lup.s_req_valid = '0;
    cyc();
    cyc();
    #1;
    check("miss_rsp_valid", lup.m_rsp_valid, 3'b010);
    check("miss_rsp_hit", lup.m_rsp_hit[1], 1'b0);
    check("miss_rsp_data", lup.m_rsp_data[1], 32'h0);
    check("miss_cnt", miss_cnt, 32'd1);
    check("miss_hit_cnt", hit_cnt, 32'd1);
    cyc();

    // Fairness from reset: all three hold valid, rotation 0,1,2 with one idle slot per round.
    do_reset();
    set_req(0, A_HIT0, 6'd3, 1'b0);
    set_req(1, A_MISS, 6'd1, 1'b0);
    set_req(2, A_HIT1, 6'd1, 1'b1);
    for (int t = 0; t < 10; t++) begin
      if (t > 0) cyc();
      lup.s_req_valid = (t < 8) ? 3'b111 : 3'b000;
      #1;
      check($sformatf("fair_rdy%0d", t), lup.s_req_ready, fair_rdy[t]);
      check($sformatf("fair_rsp%0d", t), lup.m_rsp_valid, fair_rsp[t]);
    end
    cyc();
    cyc();

    // Backpressure on requester 2 for 22 cycles: it stays parked while 0 and 1 keep cycling.
    lup.m_rsp_ready = 3'b011;
    gcnt0 = 0;
    gcnt1 = 0;
    gcnt2 = 0;
    n_v2 = 0;
    for (int t = 0; t < 22; t++) begin
      lup.s_req_valid = 3'b111;
      #1;
      gcnt0 += int'(lup.s_req_ready[0]);
      gcnt1 += int'(lup.s_req_ready[1]);
      gcnt2 += int'(lup.s_req_ready[2]);
      n_v2  += int'(lup.m_rsp_valid[2]);
      cyc();
    end
    #1;
    check("bp_grants0", gcnt0, 6);
    check("bp_grants1", gcnt1, 6);
    check("bp_grants2", gcnt2, 1);
    check("bp_rsp2_held", n_v2, 17);
    check("bp_rsp2_hit", lup.m_rsp_hit[2], 1'b1);
    check("bp_rsp2_data", lup.m_rsp_data[2], 32'hBEEF_0002);
    lup.s_req_valid = '0;
    lup.m_rsp_ready = '1;
    cyc();
    cyc();
    cyc();
    cyc();
    #1;
    check("bp_drain", lup.m_rsp_valid, 3'b000);

    // Pause one cycle after a grant: that lookup completes, nothing new issues until release.
    set_req(0, A_HIT0, 6'd3, 1'b0);
    #1;
    check("pause_pre_grant", lup.s_req_ready, 3'b001);
    cyc();
    lup.s_req_valid = '0;
    set_req(1, A_MISS, 6'd1, 1'b0);
    pause = 1'b1;
    any_rdy = 0;
    tlbv = 0;
    seen0 = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      any_rdy += int'(lup.s_req_ready != 3'b000);
      tlbv    += int'(tlb.valid);
      seen0   += int'(lup.m_rsp_valid[0]);
      cyc();
    end
    check("pause_no_grant", any_rdy, 0);
    check("pause_tlb_pulses", tlbv, 1);
    check("pause_inflight_rsp", seen0, 1);
    pause = 1'b0;
    #1;
    check("pause_resume", lup.s_req_ready, 3'b010);
    cyc();
    lup.s_req_valid = '0;
    #1;
    check("resume_issue", tlb.valid, 1'b1);
    check("resume_addr", tlb.addr, A_MISS);
    cyc();
    cyc();
    cyc();
    cyc();

    // Reset with two lookups in flight: everything drops and nothing comes back.
    set_req(0, A_HIT0, 6'd3, 1'b0);
    set_req(1, A_HIT1, 6'd1, 1'b0);
    #1;
    check("midrst_grant0", lup.s_req_ready, 3'b001);
    cyc();
    #1;
    check("midrst_grant1", lup.s_req_ready, 3'b010);
    cyc();
    lup.s_req_valid = '0;
    areset = 1'b1;
    #1;
    check("midrst_tlb_valid", tlb.valid, 1'b0);
    check("midrst_rsp_valid", lup.m_rsp_valid, 3'b000);
    check("midrst_hit_cnt", hit_cnt, 32'h0);
    check("midrst_miss_cnt", miss_cnt, 32'h0);
    cyc();
    areset = 1'b0;
    leak = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      leak += int'(lup.m_rsp_valid != 3'b000) + int'(tlb.valid);
      cyc();
    end
    check("midrst_no_rsp", leak, 0);

    // Saturation: preload the hit counter just below the top, then three hits.
    force dut.hit_cnt_q = 32'hFFFF_FFFE;
    cyc();
    release dut.hit_cnt_q;
    #1;
    check("sat_preload", hit_cnt, 32'hFFFF_FFFE);
    one_lookup(0, A_HIT0, 6'd3);
    #1;
    check("sat_first", hit_cnt, 32'hFFFF_FFFF);
    one_lookup(2, A_HIT1, 6'd1);
    one_lookup(0, A_HIT0, 6'd3);
    #1;
    check("sat_hold", hit_cnt, 32'hFFFF_FFFF);
    check("sat_miss_cnt", miss_cnt, 32'h0);

    // Clear in the capture cycle of a hit wins over the increment.
    cyc();
    set_req(0, A_HIT0, 6'd3, 1'b0);
    cyc();
    lup.s_req_valid = '0;
    cyc();
    stats_clr = 1'b1;
    cyc();
    stats_clr = 1'b0;
    #1;
    check("clr_wins", hit_cnt, 32'h0);
    check("clr_rsp_valid", lup.m_rsp_valid, 3'b001);
    one_lookup(1, A_HIT1, 6'd1);
    #1;
    check("clr_then_count", hit_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
